wasm_mem_requester: RTL and testbench
=====================================

// Module: wasm_mem_requester
// PURPOSE
//  Initiator side of the word-memory command interface (cmd_start/cmd_write/cmd_ready, rdata/rdata_ready).
//  Accepts WASM linear-memory load/store ops from the execute stage, computes base+offset,
//  bounds-checks, and drives one memory command per op. Sign/zero-extends loads, returns a result or trap.
// PARAMETERS
//  MEMORY_BYTES    8192  linear-memory size in bytes (2048 words)
//  TIMEOUT_CYCLES  64    max cycles in ISSUE+WAIT before timeout trap; >=2
// PORTS
//  clk             in   1   clock
//  rst_n           in   1   asynchronous, active-low reset
//  req_valid       in   1   op request valid
//  req_ready       out  1   block can accept an op (=state IDLE)
//  req_op          in   4   op code (wasm_mem_pkg)
//  req_base        in   32  dynamic address operand
//  req_offset      in   32  static memarg offset
//  req_wval        in   32  store value (low bits used for 8/16-bit stores)
//  rsp_valid       out  1   result/trap valid; held until rsp_ready
//  rsp_ready       in   1   consumer takes response
//  rsp_data        out  32  extended load value; 0 for stores and traps
//  rsp_trap        out  1   op trapped
//  rsp_cause       out  2   0 none, 1 out-of-bounds, 2 timeout, 3 illegal op
//  mem_cmd_start   out  1   command strobe (=state ISSUE)
//  mem_cmd_write   out  1   1 store, 0 load; stable while mem_cmd_start
//  mem_cmd_ready   in   1   memory idle; command accepted on edge where start&ready
//  mem_addr        out  32  byte address (effective address)
//  mem_wdata       out  32  store data, byte0 = lowest address (little-endian)
//  mem_wmask       out  32  byte mask, same byte order: 8b 0x000000FF, 16b 0x0000FFFF, 32b 0xFFFFFFFF
//  mem_rdata       in   32  load data, byte0 = lowest address
//  mem_rdata_ready in   1   memory completion; drops on accept edge, rises when done (loads and stores)
// BEHAVIOUR
//  Reset (async, rst_n=0): state IDLE; req_ready=1; rsp_valid=0, rsp_data=0, rsp_trap=0, rsp_cause=0;
//   mem_cmd_start=0, mem_cmd_write=0, mem_addr=0, mem_wdata=0, mem_wmask=0; timeout counter 0.
//  States: IDLE -> (req_valid) ISSUE | RESP(pre-trap); ISSUE -> (mem_cmd_ready) WAIT; WAIT -> (mem_rdata_ready) RESP;
//   ISSUE/WAIT -> (counter==TIMEOUT_CYCLES-1) RESP trap 2; RESP -> (rsp_ready) IDLE.
//  Accept: edge with req_valid&req_ready; op/ea/wval/size captured in registers.
//  EA = {1'b0,base}+{1'b0,offset} (33 bit). Size 1/2/4 from op. Undefined op code -> trap 3, no mem command.
//  ISSUE: mem_cmd_start=1 until accepted; mem_addr/wdata/wmask/write held constant throughout ISSUE and WAIT.
//  WAIT: mem_rdata_ready sampled only here; first WAIT cycle sees 0 (memory clears on accept edge).
//  Load completion: rsp_data = op LOAD32 rdata; LOAD8_S sext rdata[7:0]; LOAD8_U zext; LOAD16_S/U likewise [15:0].
//  Minimum latency (memory ready, 1-cycle completion): accept edge -> rsp_valid 3 cycles later.
//  Timeout counter clears on accept, increments each ISSUE/WAIT cycle; timeout abandons op (memory may still
//   finish; its late completion ignored because next op waits on mem_cmd_ready).
//  Unaligned EA issued unchanged; memory-side stall is caught by timeout.
//  RESP: rsp_* stable while rsp_valid & !rsp_ready; req_ready=0 (no accept while response pending).
//  Reset mid-op: immediate IDLE, strobe dropped, pending response discarded.
// CONFIGURATION
//  WASM_MEM_BOUNDS_CHECK_EN defined: at accept, EA[32]=1 or EA+size>MEMORY_BYTES -> RESP trap 1,
//   no memory command issued. Undefined: no bounds check; mem_addr=EA[31:0], carry discarded.
// STRUCTURE
//  Package wasm_mem_pkg: op codes (LOAD32=0, LOAD8_S=1, LOAD8_U=2, LOAD16_S=3, LOAD16_U=4, STORE32=5,
//   STORE8=6, STORE16=7), trap-cause constants, state enum, op->size/is_store helper function.
//  Sub-module wasm_load_extend: combinational op+rdata -> extended 32-bit value.
// TESTING
//  LOAD32 base=0x10 off=0x4, mem word bytes 11 22 33 44 -> rsp_data=0x44332211, trap=0.
//  LOAD8_S base=0x20 off=0, byte0=0x80 -> 0xFFFFFF80; LOAD16_U same addr, bytes 80 FF -> 0x0000FF80.
//  STORE8 base=0x30 wval=0xAABBCCDD -> wdata=0x000000DD, wmask=0x000000FF, write=1; rsp_data=0.
//  With WASM_MEM_BOUNDS_CHECK_EN: LOAD32 base=0x1FFE off=0 -> trap cause 1, mem_cmd_start never 1;
//   base=0xFFFFFFFF off=2 -> trap 1.
//  mem_cmd_ready held 0 -> trap cause 2 after exactly TIMEOUT_CYCLES cycles in ISSUE; op 0xF -> trap 3.
//  rsp_ready low 5 cycles -> rsp_* stable, req_ready=0; rst_n pulse during WAIT -> all outputs reset values.

Source files
------------

// File: rtl/wasm_mem_pkg.sv
// Shared definitions for the WASM linear-memory requester: op codes, trap
// causes, requester states and small op-decoding helpers.
package wasm_mem_pkg;

   typedef enum logic [3:0] {
      OP_LOAD32   = 4'd0,
      OP_LOAD8_S  = 4'd1,
      OP_LOAD8_U  = 4'd2,
      OP_LOAD16_S = 4'd3,
      OP_LOAD16_U = 4'd4,
      OP_STORE32  = 4'd5,
      OP_STORE8   = 4'd6,
      OP_STORE16  = 4'd7
   } mem_op_e;

   typedef enum logic [1:0] {
      CAUSE_NONE    = 2'd0,
      CAUSE_OOB     = 2'd1,
      CAUSE_TIMEOUT = 2'd2,
      CAUSE_ILLEGAL = 2'd3
   } trap_cause_e;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT,
      ST_RESP
   } req_state_e;

   // Access width in bytes; 0 marks an op code outside the defined set.
   function automatic logic [2:0] op_size(input logic [3:0] op);
      logic [2:0] size;
      case (op)
         OP_LOAD32, OP_STORE32:              size = 3'd4;
         OP_LOAD8_S, OP_LOAD8_U, OP_STORE8:  size = 3'd1;
         OP_LOAD16_S, OP_LOAD16_U, OP_STORE16: size = 3'd2;
         default:                            size = 3'd0;
      endcase
      return size;
   endfunction

   function automatic logic op_is_store(input logic [3:0] op);
      return (op == OP_STORE32) || (op == OP_STORE8) || (op == OP_STORE16);
   endfunction

   function automatic logic op_is_legal(input logic [3:0] op);
      return op <= OP_STORE16;
   endfunction

   // Byte mask in little-endian lane order: lane 0 is the lowest address.
   function automatic logic [31:0] size_mask(input logic [2:0] size);
      logic [31:0] mask;
      case (size)
         3'd1:    mask = 32'h0000_00FF;
         3'd2:    mask = 32'h0000_FFFF;
         3'd4:    mask = 32'hFFFF_FFFF;
         default: mask = 32'h0000_0000;
      endcase
      return mask;
   endfunction

   // Narrow stores only carry the low bytes of the value; loads carry no data.
   function automatic logic [31:0] store_data(input logic [3:0] op, input logic [31:0] wval);
      logic [31:0] data;
      case (op)
         OP_STORE32: data = wval;
         OP_STORE16: data = {16'h0000, wval[15:0]};
         OP_STORE8:  data = {24'h000000, wval[7:0]};
         default:    data = 32'h0000_0000;
      endcase
      return data;
   endfunction

endpackage

// File: rtl/wasm_load_extend.sv
// Combinational load-result formatter: picks the low byte/halfword of the
// returned memory word and sign- or zero-extends it according to the op.
module wasm_load_extend
   import wasm_mem_pkg::*;
(
   input  logic [3:0]  op,
   input  logic [31:0] rdata,
   output logic [31:0] ext_data
);

   // Select and extend the addressed lane; full-word loads pass straight through.
   always_comb begin
      ext_data = rdata;
      case (op)
         OP_LOAD8_S:  ext_data = {{24{rdata[7]}}, rdata[7:0]};
         OP_LOAD8_U:  ext_data = {24'h000000, rdata[7:0]};
         OP_LOAD16_S: ext_data = {{16{rdata[15]}}, rdata[15:0]};
         OP_LOAD16_U: ext_data = {16'h0000, rdata[15:0]};
         default:     ext_data = rdata;
      endcase
   end

endmodule

// File: rtl/wasm_mem_requester.sv
// WASM linear-memory requester: takes load/store ops from execute, forms the
// effective address, drives one word-memory command per op and returns the
// extended load value or a trap.
// Optional feature macro: WASM_MEM_BOUNDS_CHECK_EN enables the linear-memory
// bounds check at accept time (out-of-bounds ops trap without a memory command).
module wasm_mem_requester
   import wasm_mem_pkg::*;
#(
   parameter int MEMORY_BYTES   = 8192,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [3:0]  req_op,
   input  logic [31:0] req_base,
   input  logic [31:0] req_offset,
   input  logic [31:0] req_wval,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_data,
   output logic        rsp_trap,
   output logic [1:0]  rsp_cause,
   output logic        mem_cmd_start,
   output logic        mem_cmd_write,
   input  logic        mem_cmd_ready,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [31:0] mem_wmask,
   input  logic [31:0] mem_rdata,
   input  logic        mem_rdata_ready
);

   localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   req_state_e       state;
   logic [3:0]       op_q;
   logic [CNT_W-1:0] timeout_cnt;
   logic [2:0]       size_in;
   logic [31:0]      ea_addr;
   logic             out_of_bounds;
   logic [31:0]      load_value;

   assign size_in = op_size(req_op);

`ifdef WASM_MEM_BOUNDS_CHECK_EN
   logic [32:0] ea_wide;
   logic [33:0] ea_end;

   // Full-width effective address and end-of-access so a carry out of the
   // 32-bit add is seen as out of bounds rather than silently wrapping.
   always_comb begin
      ea_wide       = {1'b0, req_base} + {1'b0, req_offset};
      ea_end        = {1'b0, ea_wide} + 34'(size_in);
      out_of_bounds = ea_wide[32] | (ea_end > 34'(MEMORY_BYTES));
   end

   assign ea_addr = ea_wide[31:0];
`else
   assign ea_addr       = req_base + req_offset;
   assign out_of_bounds = 1'b0;
`endif

   wasm_load_extend u_load_extend (
      .op       (op_q),
      .rdata    (mem_rdata),
      .ext_data (load_value)
   );

   // Request FSM: accept an op, issue it, wait for completion or timeout, then
   // hold the response until the consumer takes it. All outputs are registered.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= ST_IDLE;
         op_q          <= 4'd0;
         timeout_cnt   <= '0;
         req_ready     <= 1'b1;
         rsp_valid     <= 1'b0;
         rsp_data      <= 32'h0;
         rsp_trap      <= 1'b0;
         rsp_cause     <= CAUSE_NONE;
         mem_cmd_start <= 1'b0;
         mem_cmd_write <= 1'b0;
         mem_addr      <= 32'h0;
         mem_wdata     <= 32'h0;
         mem_wmask     <= 32'h0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (req_valid) begin
                  op_q        <= req_op;
                  timeout_cnt <= '0;
                  req_ready   <= 1'b0;
                  if (!op_is_legal(req_op)) begin
                     state     <= ST_RESP;
                     rsp_valid <= 1'b1;
                     rsp_trap  <= 1'b1;
                     rsp_cause <= CAUSE_ILLEGAL;
                     rsp_data  <= 32'h0;
                  end else if (out_of_bounds) begin
                     state     <= ST_RESP;
                     rsp_valid <= 1'b1;
                     rsp_trap  <= 1'b1;
                     rsp_cause <= CAUSE_OOB;
                     rsp_data  <= 32'h0;
                  end else begin
                     state         <= ST_ISSUE;
                     mem_cmd_start <= 1'b1;
                     mem_cmd_write <= op_is_store(req_op);
                     mem_addr      <= ea_addr;
                     mem_wdata     <= store_data(req_op, req_wval);
                     mem_wmask     <= size_mask(size_in);
                  end
               end
            end

            ST_ISSUE: begin
               // Timeout wins so the bound on ISSUE+WAIT is exact.
               if (timeout_cnt == CNT_LAST) begin
                  state         <= ST_RESP;
                  mem_cmd_start <= 1'b0;
                  rsp_valid     <= 1'b1;
                  rsp_trap      <= 1'b1;
                  rsp_cause     <= CAUSE_TIMEOUT;
                  rsp_data      <= 32'h0;
               end else if (mem_cmd_ready) begin
                  state         <= ST_WAIT;
                  mem_cmd_start <= 1'b0;
                  timeout_cnt   <= timeout_cnt + 1'b1;
               end else begin
                  timeout_cnt <= timeout_cnt + 1'b1;
               end
            end

            ST_WAIT: begin
               if (timeout_cnt == CNT_LAST) begin
                  state     <= ST_RESP;
                  rsp_valid <= 1'b1;
                  rsp_trap  <= 1'b1;
                  rsp_cause <= CAUSE_TIMEOUT;
                  rsp_data  <= 32'h0;
               end else if (mem_rdata_ready) begin
                  state     <= ST_RESP;
                  rsp_valid <= 1'b1;
                  rsp_trap  <= 1'b0;
                  rsp_cause <= CAUSE_NONE;
                  rsp_data  <= op_is_store(op_q) ? 32'h0 : load_value;
               end else begin
                  timeout_cnt <= timeout_cnt + 1'b1;
               end
            end

            ST_RESP: begin
               if (rsp_ready) begin
                  state     <= ST_IDLE;
                  req_ready <= 1'b1;
                  rsp_valid <= 1'b0;
                  rsp_data  <= 32'h0;
                  rsp_trap  <= 1'b0;
                  rsp_cause <= CAUSE_NONE;
               end
            end

            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_wasm_mem_requester.sv
// Directed bench for wasm_mem_requester with a small byte-addressed memory
// model on the command interface. Honours WASM_MEM_BOUNDS_CHECK_EN.
module tb_wasm_mem_requester;

   localparam logic [3:0] LOAD32   = 4'd0;
   localparam logic [3:0] LOAD8_S  = 4'd1;
   localparam logic [3:0] LOAD8_U  = 4'd2;
   localparam logic [3:0] LOAD16_S = 4'd3;
   localparam logic [3:0] LOAD16_U = 4'd4;
   localparam logic [3:0] STORE32  = 4'd5;
   localparam logic [3:0] STORE8   = 4'd6;
   localparam logic [3:0] STORE16  = 4'd7;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [3:0]  req_op = 4'd0;
   logic [31:0] req_base = 32'h0;
   logic [31:0] req_offset = 32'h0;
   logic [31:0] req_wval = 32'h0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b1;
   logic [31:0] rsp_data;
   logic        rsp_trap;
   logic [1:0]  rsp_cause;
   logic        mem_cmd_start;
   logic        mem_cmd_write;
   logic        mem_cmd_ready = 1'b1;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_wmask;
   logic [31:0] mem_rdata = 32'h0;
   logic        mem_rdata_ready = 1'b0;

   int tests_run = 0;
   int tests_failed = 0;

   // Observations collected by applyStimulus for one operation
   bit          obs_got;
   int          obs_lat;
   int          obs_start;
   logic [31:0] obs_data;
   logic        obs_trap;
   logic [1:0]  obs_cause;
   logic [31:0] obs_addr;
   logic [31:0] obs_wdata;
   logic [31:0] obs_wmask;
   logic        obs_write;

   // Memory model state
   logic [7:0]  mem_bytes [0:8191];
   bit          busy = 1'b0;
   bit          acc_pending = 1'b0;
   int          busy_cnt = 0;
   int          mem_lat = 0;
   bit          stall_cmd = 1'b0;

   wasm_mem_requester #(
      .MEMORY_BYTES   (8192),
      .TIMEOUT_CYCLES (64)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .req_valid       (req_valid),
      .req_ready       (req_ready),
      .req_op          (req_op),
      .req_base        (req_base),
      .req_offset      (req_offset),
      .req_wval        (req_wval),
      .rsp_valid       (rsp_valid),
      .rsp_ready       (rsp_ready),
      .rsp_data        (rsp_data),
      .rsp_trap        (rsp_trap),
      .rsp_cause       (rsp_cause),
      .mem_cmd_start   (mem_cmd_start),
      .mem_cmd_write   (mem_cmd_write),
      .mem_cmd_ready   (mem_cmd_ready),
      .mem_addr        (mem_addr),
      .mem_wdata       (mem_wdata),
      .mem_wmask       (mem_wmask),
      .mem_rdata       (mem_rdata),
      .mem_rdata_ready (mem_rdata_ready)
   );

   // 100 MHz clock
   always #5 clk = ~clk;

   // Hard stop in case something wedges
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   // Memory model, updated on the falling edge so the DUT sees stable inputs at
   // every rising edge. acc_pending records that the coming rising edge accepts
   // a command; the next falling edge performs it and makes the memory busy.
   always @(negedge clk) begin
      if (!rst_n) begin
         busy            = 1'b0;
         acc_pending     = 1'b0;
         busy_cnt        = 0;
         mem_rdata_ready = 1'b0;
         mem_cmd_ready   = 1'b1;
      end else begin
         if (acc_pending) begin
            acc_pending     = 1'b0;
            busy            = 1'b1;
            busy_cnt        = mem_lat;
            mem_rdata_ready = 1'b0;
            for (int k = 0; k < 4; k++) begin
               if (mem_cmd_write) begin
                  if (mem_wmask[8*k])
                     mem_bytes[13'(mem_addr[12:0] + 13'(k))] = mem_wdata[8*k +: 8];
               end else begin
                  mem_rdata[8*k +: 8] = mem_bytes[13'(mem_addr[12:0] + 13'(k))];
               end
            end
         end else if (busy) begin
            if (busy_cnt == 0) begin
               busy            = 1'b0;
               mem_rdata_ready = 1'b1;
            end else begin
               busy_cnt = busy_cnt - 1;
            end
         end
         mem_cmd_ready = !busy && !stall_cmd;
         acc_pending   = mem_cmd_start && mem_cmd_ready;
      end
   end

   // Single comparison point: counts every check and reports mismatches
   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
      end
   endtask

   // Present one op, then watch the DUT until it responds (bounded). When hold
   // is set the response is left pending for the caller to release.
   task automatic applyStimulus(input logic [3:0] op, input logic [31:0] base,
                                input logic [31:0] off, input logic [31:0] wval,
                                input bit hold);
      @(negedge clk);
      req_valid  = 1'b1;
      req_op     = op;
      req_base   = base;
      req_offset = off;
      req_wval   = wval;
      rsp_ready  = !hold;
      @(posedge clk);
      #1 req_valid = 1'b0;
      obs_got = 1'b0; obs_lat = -1; obs_start = 0;
      obs_data = 32'h0; obs_trap = 1'b0; obs_cause = 2'd0;
      obs_addr = 32'h0; obs_wdata = 32'h0; obs_wmask = 32'h0; obs_write = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (mem_cmd_start) begin
            obs_start++;
            obs_addr  = mem_addr;
            obs_wdata = mem_wdata;
            obs_wmask = mem_wmask;
            obs_write = mem_cmd_write;
         end
         if (rsp_valid) begin
            obs_got   = 1'b1;
            obs_lat   = i;
            obs_data  = rsp_data;
            obs_trap  = rsp_trap;
            obs_cause = rsp_cause;
            break;
         end
      end
      if (!obs_got) checkOutput("rsp_valid_within_bound", {31'b0, rsp_valid}, 32'h1);
      if (!hold) @(posedge clk);
   endtask

   // Checks every output against its reset value
   task automatic checkResetValues(input string tag);
      checkOutput({tag, "_req_ready"}, {31'b0, req_ready}, 32'h1);
      checkOutput({tag, "_rsp_valid"}, {31'b0, rsp_valid}, 32'h0);
      checkOutput({tag, "_rsp_data"},  rsp_data,           32'h0);
      checkOutput({tag, "_rsp_trap"},  {31'b0, rsp_trap},  32'h0);
      checkOutput({tag, "_rsp_cause"}, {30'b0, rsp_cause}, 32'h0);
      checkOutput({tag, "_cmd_start"}, {31'b0, mem_cmd_start}, 32'h0);
      checkOutput({tag, "_cmd_write"}, {31'b0, mem_cmd_write}, 32'h0);
      checkOutput({tag, "_mem_addr"},  mem_addr,  32'h0);
      checkOutput({tag, "_mem_wdata"}, mem_wdata, 32'h0);
      checkOutput({tag, "_mem_wmask"}, mem_wmask, 32'h0);
   endtask

   // Main directed sequence
   initial begin
      logic [31:0] held_data;
      bit started;
      bit seen_wait;

      for (int a = 0; a < 8192; a++) mem_bytes[a] = 8'h00;
      mem_bytes[16'h14] = 8'h11; mem_bytes[16'h15] = 8'h22;
      mem_bytes[16'h16] = 8'h33; mem_bytes[16'h17] = 8'h44;
      mem_bytes[16'h20] = 8'h80; mem_bytes[16'h21] = 8'hFF;
      mem_bytes[16'h22] = 8'h7F;
      mem_bytes[16'h1FFC] = 8'h01; mem_bytes[16'h1FFD] = 8'h02;
      mem_bytes[16'h1FFE] = 8'h03; mem_bytes[16'h1FFF] = 8'h04;

      repeat (3) @(posedge clk);
      #1 checkResetValues("reset");
      @(negedge clk);
      rst_n = 1'b1;

      // Word load with minimum latency
      applyStimulus(LOAD32, 32'h10, 32'h4, 32'h0, 1'b0);
      checkOutput("load32_data",    obs_data, 32'h4433_2211);
      checkOutput("load32_trap",    {31'b0, obs_trap}, 32'h0);
      checkOutput("load32_latency", obs_lat, 3);
      checkOutput("load32_addr",    obs_addr, 32'h14);
      checkOutput("load32_write",   {31'b0, obs_write}, 32'h0);
      checkOutput("load32_wmask",   obs_wmask, 32'hFFFF_FFFF);

      // Sub-word loads with sign/zero extension
      applyStimulus(LOAD8_S, 32'h20, 32'h0, 32'h0, 1'b0);
      checkOutput("load8s_data", obs_data, 32'hFFFF_FF80);
      checkOutput("load8s_wmask", obs_wmask, 32'h0000_00FF);
      applyStimulus(LOAD8_U, 32'h20, 32'h0, 32'h0, 1'b0);
      checkOutput("load8u_data", obs_data, 32'h0000_0080);
      applyStimulus(LOAD16_U, 32'h20, 32'h0, 32'h0, 1'b0);
      checkOutput("load16u_data", obs_data, 32'h0000_FF80);
      applyStimulus(LOAD16_S, 32'h20, 32'h0, 32'h0, 1'b0);
      checkOutput("load16s_data", obs_data, 32'hFFFF_FF80);
      applyStimulus(LOAD16_S, 32'h1F, 32'h2, 32'h0, 1'b0);
      checkOutput("load16s_unaligned_addr", obs_addr, 32'h21);
      checkOutput("load16s_unaligned_data", obs_data, 32'h0000_7FFF);

      // Stores: command fields, then read back through word loads
      applyStimulus(STORE8, 32'h30, 32'h0, 32'hAABB_CCDD, 1'b0);
      checkOutput("store8_wdata", obs_wdata, 32'h0000_00DD);
      checkOutput("store8_wmask", obs_wmask, 32'h0000_00FF);
      checkOutput("store8_write", {31'b0, obs_write}, 32'h1);
      checkOutput("store8_rsp_data", obs_data, 32'h0);
      checkOutput("store8_trap", {31'b0, obs_trap}, 32'h0);
      applyStimulus(STORE16, 32'h34, 32'h0, 32'h1234_5678, 1'b0);
      checkOutput("store16_wdata", obs_wdata, 32'h0000_5678);
      checkOutput("store16_wmask", obs_wmask, 32'h0000_FFFF);
      applyStimulus(STORE32, 32'h30, 32'h8, 32'hCAFE_BABE, 1'b0);
      checkOutput("store32_wdata", obs_wdata, 32'hCAFE_BABE);
      checkOutput("store32_wmask", obs_wmask, 32'hFFFF_FFFF);
      checkOutput("store32_addr",  obs_addr,  32'h38);
      applyStimulus(LOAD32, 32'h30, 32'h0, 32'h0, 1'b0);
      checkOutput("readback_store8", obs_data, 32'h0000_00DD);
      applyStimulus(LOAD32, 32'h34, 32'h0, 32'h0, 1'b0);
      checkOutput("readback_store16", obs_data, 32'h0000_5678);
      applyStimulus(LOAD32, 32'h38, 32'h0, 32'h0, 1'b0);
      checkOutput("readback_store32", obs_data, 32'hCAFE_BABE);

      // Illegal op code traps without touching memory
      applyStimulus(4'hF, 32'h10, 32'h0, 32'h0, 1'b0);
      checkOutput("illegal_trap",  {31'b0, obs_trap}, 32'h1);
      checkOutput("illegal_cause", {30'b0, obs_cause}, 32'h3);
      checkOutput("illegal_no_cmd", obs_start, 0);
      checkOutput("illegal_data", obs_data, 32'h0);

      // Last in-bounds word
      applyStimulus(LOAD32, 32'h1FFC, 32'h0, 32'h0, 1'b0);
      checkOutput("edge_inbounds_trap", {31'b0, obs_trap}, 32'h0);
      checkOutput("edge_inbounds_data", obs_data, 32'h0403_0201);

`ifdef WASM_MEM_BOUNDS_CHECK_EN
      applyStimulus(LOAD32, 32'h1FFE, 32'h0, 32'h0, 1'b0);
      checkOutput("oob_end_trap",  {31'b0, obs_trap}, 32'h1);
      checkOutput("oob_end_cause", {30'b0, obs_cause}, 32'h1);
      checkOutput("oob_end_no_cmd", obs_start, 0);
      applyStimulus(LOAD32, 32'hFFFF_FFFF, 32'h2, 32'h0, 1'b0);
      checkOutput("oob_carry_trap",  {31'b0, obs_trap}, 32'h1);
      checkOutput("oob_carry_cause", {30'b0, obs_cause}, 32'h1);
      checkOutput("oob_carry_no_cmd", obs_start, 0);
`else
      applyStimulus(LOAD32, 32'h1FFE, 32'h0, 32'h0, 1'b0);
      checkOutput("nocheck_end_trap", {31'b0, obs_trap}, 32'h0);
      checkOutput("nocheck_end_addr", obs_addr, 32'h1FFE);
      checkOutput("nocheck_end_data", obs_data, 32'h0000_0403);
      applyStimulus(LOAD32, 32'hFFFF_FFFF, 32'h2, 32'h0, 1'b0);
      checkOutput("nocheck_carry_trap", {31'b0, obs_trap}, 32'h0);
      checkOutput("nocheck_carry_addr", obs_addr, 32'h1);
`endif

      // Memory never accepts: timeout after exactly 64 ISSUE cycles
      @(negedge clk);
      stall_cmd = 1'b1;
      applyStimulus(LOAD32, 32'h40, 32'h0, 32'h0, 1'b0);
      checkOutput("timeout_trap",  {31'b0, obs_trap}, 32'h1);
      checkOutput("timeout_cause", {30'b0, obs_cause}, 32'h2);
      checkOutput("timeout_issue_cycles", obs_start, 64);
      checkOutput("timeout_latency", obs_lat, 64);
      checkOutput("timeout_data", obs_data, 32'h0);
      stall_cmd = 1'b0;

      // Response held for 5 cycles: outputs stable, no new accept
      applyStimulus(LOAD32, 32'h10, 32'h4, 32'h0, 1'b1);
      held_data = obs_data;
      checkOutput("hold_first_data", held_data, 32'h4433_2211);
      req_valid = 1'b1;
      req_op    = LOAD8_U;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         checkOutput("hold_rsp_valid", {31'b0, rsp_valid}, 32'h1);
         checkOutput("hold_rsp_data",  rsp_data, 32'h4433_2211);
         checkOutput("hold_rsp_trap",  {31'b0, rsp_trap}, 32'h0);
         checkOutput("hold_req_ready", {31'b0, req_ready}, 32'h0);
      end
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      @(posedge clk);
      #1 checkOutput("hold_release_valid", {31'b0, rsp_valid}, 32'h0);
      checkOutput("hold_release_req_ready", {31'b0, req_ready}, 32'h1);

      // Reset asserted while the requester waits on a slow memory
      mem_lat = 10;
      @(negedge clk);
      req_valid  = 1'b1;
      req_op     = LOAD32;
      req_base   = 32'h10;
      req_offset = 32'h4;
      @(posedge clk);
      #1 req_valid = 1'b0;
      started = 1'b0;
      seen_wait = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (started && !mem_cmd_start) begin
            seen_wait = 1'b1;
            break;
         end
         if (mem_cmd_start) started = 1'b1;
      end
      checkOutput("reach_wait", {31'b0, seen_wait}, 32'h1);
      #2 rst_n = 1'b0;
      #1 checkResetValues("midop_reset");
      @(negedge clk);
      @(posedge clk);
      #1 rst_n = 1'b1;
      mem_lat = 0;

      // Normal operation resumes after reset
      applyStimulus(LOAD32, 32'h10, 32'h4, 32'h0, 1'b0);
      checkOutput("post_reset_data", obs_data, 32'h4433_2211);
      checkOutput("post_reset_latency", obs_lat, 3);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
